// File: rtl/bcd_to_mag_pkg.sv
// -----------------------------------------------------------------------------
// bcd_to_mag_pkg
// Shared types and constants for the three-digit BCD to binary magnitude
// converter (reverse double-dabble).
//   state_t       : converter FSM states
//   NDIG          : number of BCD digits (hundreds, tens, units)
//   BCD_W         : width of the packed BCD word
//   BIN_W         : width of the binary accumulator (holds 0..999)
//   NSHIFT        : shift iterations per conversion
//   BCD_ADJ       : correction subtracted from a digit that reaches 8 or more
//   any_digit_bad : true when any packed digit is outside 0..9
// -----------------------------------------------------------------------------
package bcd_to_mag_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int NDIG    = 3;
    localparam int BCD_W   = 12;
    localparam int BIN_W   = 10;
    localparam int NSHIFT  = 10;
    localparam int BCD_ADJ = 3;

    function automatic logic any_digit_bad(input logic [BCD_W-1:0] word);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (word[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_mag_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Per-digit correction for reverse double-dabble. After a right shift, a BCD
// digit that is 8 or more received a carried-in 1 worth 8 from the digit
// above, but in decimal that carry is worth only 5, so 3 is taken back.
//   d_in  : 4-bit digit after the shift
//   d_out : corrected digit (d_in - 3 when d_in >= 8, else d_in)
// The subtraction cannot wrap since it only fires for d_in >= 8.
// -----------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_to_mag_pkg::*;
(
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    assign d_out = (d_in >= 4'd8) ? (d_in - 4'(BCD_ADJ)) : d_in;

endmodule

// File: rtl/bcd_to_mag.sv
// -----------------------------------------------------------------------------
// bcd_to_mag
// Sequential converter from three BCD digits plus a sign bit to a binary
// sign-magnitude value, using reverse double-dabble (shift right, then
// subtract 3 from any digit >= 8). One conversion takes 10 shift cycles.
//
// Parameters
//   MAG_W : output magnitude width (valid range 0..2^MAG_W-1, MAG_W <= 31)
//   SAT   : 1 = saturate to all-ones on overflow, 0 = keep low MAG_W bits
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : conversion request, sampled only in IDLE
//   sign_in   : operand sign (1 = negative)
//   hundred   : BCD hundreds digit
//   tens      : BCD tens digit
//   unit      : BCD units digit
//   mag       : converted magnitude (held until the next accepted start)
//   sign      : output sign, negative zero forced to +0
//   busy      : high while shifting
//   done      : one-cycle completion pulse
//   err_digit : some input digit was above 9 (no conversion performed)
//   err_ovf   : decimal value exceeded 2^MAG_W-1
//
// States
//   IDLE  | waiting for start; results and flags hold
//   SHIFT | one reverse double-dabble iteration per clock, 10 in total
// -----------------------------------------------------------------------------
module bcd_to_mag
    import bcd_to_mag_pkg::*;
#(
    parameter int MAG_W = 8,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign_in,
    input  logic [3:0]       hundred,
    input  logic [3:0]       tens,
    input  logic [3:0]       unit,
    output logic [MAG_W-1:0] mag,
    output logic             sign,
    output logic             busy,
    output logic             done,
    output logic             err_digit,
    output logic             err_ovf
);

    localparam int unsigned MAG_MAX  = (32'd1 << MAG_W) - 32'd1;
    localparam logic [3:0]  LAST_CNT = 4'(NSHIFT - 1);

    state_t                   state;
    logic [BCD_W-1:0]         bcd_q;
    logic [BIN_W-1:0]         acc_q;
    logic [3:0]               cnt_q;
    logic                     sign_lat;

    logic [BCD_W-1:0]         bcd_in;
    logic                     digit_bad;
    logic [BCD_W+BIN_W-1:0]   shifted;
    logic [BCD_W-1:0]         bcd_sh;
    logic [BCD_W-1:0]         bcd_adj;
    logic [BIN_W-1:0]         acc_sh;
    logic                     ovf_calc;
    logic [MAG_W-1:0]         mag_calc;

    assign bcd_in    = {hundred, tens, unit};
    assign digit_bad = any_digit_bad(bcd_in);

    // One iteration: the whole {bcd, acc} word moves right by one bit, the
    // units digit LSB dropping into the accumulator MSB.
    assign shifted = {bcd_q, acc_q} >> 1;
    assign bcd_sh  = shifted[BCD_W+BIN_W-1:BIN_W];
    assign acc_sh  = shifted[BIN_W-1:0];

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_in  (bcd_sh[4*g +: 4]),
            .d_out (bcd_adj[4*g +: 4])
        );
    end

    // On the final iteration acc_sh already holds the full binary value, so
    // the result is taken from it directly rather than from acc_q a cycle late.
    assign ovf_calc = (32'(acc_sh) > MAG_MAX);
    assign mag_calc = (ovf_calc && SAT) ? {MAG_W{1'b1}} : MAG_W'(acc_sh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bcd_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_lat  <= 1'b0;
            mag       <= '0;
            sign      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_digit <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd_q     <= bcd_in;
                        sign_lat  <= sign_in;
                        err_digit <= 1'b0;
                        err_ovf   <= 1'b0;
                        if (digit_bad) begin
                            // Reject without converting; report in one edge.
                            err_digit <= 1'b1;
                            mag       <= '0;
                            sign      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            cnt_q <= '0;
                            acc_q <= '0;
                            state <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    bcd_q <= bcd_adj;
                    acc_q <= acc_sh;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        mag     <= mag_calc;
                        sign    <= sign_lat && (acc_sh != '0);
                        err_ovf <= ovf_calc;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_mag.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_mag
// Directed bench for bcd_to_mag. Two instances share all inputs: dut uses the
// default saturating build, dut_wrap keeps the low bits on overflow. Each
// accepted request pushes its hand-computed result into per-instance queues;
// monitors pop and compare whenever done is seen.
// -----------------------------------------------------------------------------
module tb_bcd_to_mag;

    typedef struct {
        logic [7:0] mag;
        logic       sign;
        logic       ed;
        logic       ovf;
        int         lat;
        int         issue;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sign_in;
    logic [3:0] hundred;
    logic [3:0] tens;
    logic [3:0] unit;

    logic [7:0] mag,  mag_w;
    logic       sign, sign_w;
    logic       busy, busy_w;
    logic       done, done_w;
    logic       err_digit, err_digit_w;
    logic       err_ovf, err_ovf_w;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    exp_t q_sat[$];
    exp_t q_wrap[$];
    exp_t e_sat;
    exp_t e_wrap;

    bcd_to_mag #(.MAG_W(8), .SAT(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sign_in   (sign_in),
        .hundred   (hundred),
        .tens      (tens),
        .unit      (unit),
        .mag       (mag),
        .sign      (sign),
        .busy      (busy),
        .done      (done),
        .err_digit (err_digit),
        .err_ovf   (err_ovf)
    );

    bcd_to_mag #(.MAG_W(8), .SAT(1'b0)) dut_wrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sign_in   (sign_in),
        .hundred   (hundred),
        .tens      (tens),
        .unit      (unit),
        .mag       (mag_w),
        .sign      (sign_w),
        .busy      (busy_w),
        .done      (done_w),
        .err_digit (err_digit_w),
        .err_ovf   (err_ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (busy) busy_cnt++;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor for the saturating instance.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q_sat.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e_sat = q_sat.pop_front();
                check("sat_mag",       int'(mag),       int'(e_sat.mag));
                check("sat_sign",      int'(sign),      int'(e_sat.sign));
                check("sat_err_digit", int'(err_digit), int'(e_sat.ed));
                check("sat_err_ovf",   int'(err_ovf),   int'(e_sat.ovf));
                check("sat_latency",   cyc - e_sat.issue, e_sat.lat);
                check("sat_busy_at_done", int'(busy), 0);
            end
        end
    end

    // Monitor for the wrapping instance.
    always @(negedge clk) begin
        if (rst_n && done_w) begin
            if (q_wrap.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done_wrap actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e_wrap = q_wrap.pop_front();
                check("wrap_mag",       int'(mag_w),       int'(e_wrap.mag));
                check("wrap_sign",      int'(sign_w),      int'(e_wrap.sign));
                check("wrap_err_digit", int'(err_digit_w), int'(e_wrap.ed));
                check("wrap_err_ovf",   int'(err_ovf_w),   int'(e_wrap.ovf));
            end
        end
    end

    task automatic push(input logic [7:0] m_sat, input logic [7:0] m_wrap, input logic sg,
                        input logic ed, input logic ovf, input int issue);
        exp_t e;
        e.sign  = sg;
        e.ed    = ed;
        e.ovf   = ovf;
        e.lat   = ed ? 1 : 11;
        e.issue = issue;
        e.mag   = m_sat;
        q_sat.push_back(e);
        e.mag   = m_wrap;
        q_wrap.push_back(e);
    endtask

    // Present one start pulse; expectation pushed only when do_push is set.
    task automatic issue(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                         input logic s, input bit do_push,
                         input logic [7:0] m_sat, input logic [7:0] m_wrap,
                         input logic sg, input logic ed, input logic ovf);
        hundred = h;
        tens    = t;
        unit    = u;
        sign_in = s;
        start   = 1'b1;
        if (do_push) push(m_sat, m_wrap, sg, ed, ovf, cyc);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && q_sat.size() != 0; i++) @(posedge clk);
        check(name, q_sat.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mag"},       int'(mag),       0);
        check({tag, "_sign"},      int'(sign),      0);
        check({tag, "_busy"},      int'(busy),      0);
        check({tag, "_done"},      int'(done),      0);
        check({tag, "_err_digit"}, int'(err_digit), 0);
        check({tag, "_err_ovf"},   int'(err_ovf),   0);
    endtask

    int c0;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        sign_in = 1'b0;
        hundred = 4'd0;
        tens    = 4'd0;
        unit    = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 255: largest in-range value, busy for exactly 10 cycles.
        busy_cnt = 0;
        issue(4'd2, 4'd5, 4'd5, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        drain("drain_255");
        check("busy_cycles_255", busy_cnt, 10);

        // 128 negative, then negative zero.
        issue(4'd1, 4'd2, 4'd8, 1'b1, 1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
        drain("drain_128");
        issue(4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        drain("drain_neg0");

        // Overflow: 999 and the boundary 256.
        issue(4'd9, 4'd9, 4'd9, 1'b0, 1'b1, 8'hFF, 8'hE7, 1'b0, 1'b0, 1'b1);
        drain("drain_999");
        issue(4'd2, 4'd5, 4'd6, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
        drain("drain_256");

        // Small negative value.
        issue(4'd0, 4'd0, 4'd9, 1'b1, 1'b1, 8'h09, 8'h09, 1'b1, 1'b0, 1'b0);
        drain("drain_009");

        // Bad tens digit: immediate done, busy never seen.
        busy_cnt = 0;
        issue(4'd1, 4'hA, 4'd3, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        drain("drain_digit_err");
        check("busy_cycles_digit_err", busy_cnt, 0);

        // Start during shifting is ignored.
        issue(4'd0, 4'd6, 4'd3, 1'b0, 1'b1, 8'h3F, 8'h3F, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        hundred = 4'd0;
        tens    = 4'd0;
        unit    = 4'd7;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        drain("drain_ignore");
        repeat (15) @(posedge clk);
        #1;

        // Reset mid-conversion: everything cleared, no done afterwards.
        issue(4'd4, 4'd5, 4'd6, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("midreset_queue", q_sat.size(), 0);

        issue(4'd0, 4'd4, 4'd2, 1'b0, 1'b1, 8'h2A, 8'h2A, 1'b0, 1'b0, 1'b0);
        drain("drain_042");

        // Back-to-back: start held through done, second accepted on done cycle.
        c0      = cyc;
        hundred = 4'd1;
        tens    = 4'd0;
        unit    = 4'd0;
        sign_in = 1'b0;
        start   = 1'b1;
        push(8'h64, 8'h64, 1'b0, 1'b0, 1'b0, c0);
        @(posedge clk);
        #1;
        hundred = 4'd0;
        tens    = 4'd3;
        unit    = 4'd7;
        push(8'h25, 8'h25, 1'b0, 1'b0, 1'b0, c0 + 11);
        repeat (11) @(posedge clk);
        #1 start = 1'b0;
        drain("drain_b2b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
